// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the Uart receive port, the rx FIFO and its consumer.
// The FIFO is the slave; whoever drives the Uart side and the consumer pop is the master.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic [DATA_WIDTH-1:0] uart_data_i;
  logic                  uart_ready_i;
  logic                  uart_ack_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [DEPTH_LOG2:0]   count_o;
  logic                  full_o;
  logic                  overrun_o;
  logic                  clear_overrun_i;

  modport slave (
    input  uart_data_i, uart_ready_i, ready_i, clear_overrun_i,
    output uart_ack_o, data_o, valid_o, count_o, full_o, overrun_o
  );

  modport master (
    output uart_data_i, uart_ready_i, ready_i, clear_overrun_i,
    input  uart_ack_o, data_o, valid_o, count_o, full_o, overrun_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Drains bytes from the Uart read port into a circular FIFO and presents them
// show-ahead to a consumer; bytes arriving while full are acked, dropped and flagged.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  uart_rx_fifo_if.slave    bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} cap_state_e;

  cap_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  full_q, full_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic capture, uart_ack, pop, wr_en, drop;

  // Capture FSM: one push per Uart byte, however long read_ready stays high.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    uart_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.uart_ready_i) begin
          capture = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        uart_ack = 1'b1;
        state_d  = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.uart_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop       = valid_q && bus.ready_i;
    wr_en     = capture && (!full_q || pop);
    drop      = capture && full_q && !pop;
    wr_ptr_d  = wr_en ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d  = pop   ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d   = (count_d != '0);
    full_d    = (count_d == CNT_W'(DEPTH));
    // The head register loads the post-edge head; when that slot is being
    // written this same edge, the incoming byte is what will live there.
    if (wr_en && (wr_ptr_q == rd_ptr_d)) data_d = bus.uart_data_i;
    else                                 data_d = mem_q[rd_ptr_d];
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)                     overrun_d = 1'b1;
    else if (bus.clear_overrun_i) overrun_d = 1'b0;
    else                          overrun_d = overrun_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
      data_q    <= data_d;
    end
  end

  // Storage is deliberately left out of reset; occupancy lives in count_q.
  always_ff @(posedge clock_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.uart_data_i;
  end

  assign bus.uart_ack_o = uart_ack;
  assign bus.data_o     = data_q;
  assign bus.valid_o    = valid_q;
  assign bus.count_o    = count_q;
  assign bus.full_o     = full_q;
  assign bus.overrun_o  = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a vector table for the single-byte path, then
// queue-model-checked sequences for full/overrun/wrap/reset corners.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  bit         m_ovr;
  bit         m_ack;
  bit         prev_rdy;
  bit         rand_pop;

  typedef struct {
    bit         u_rdy;
    logic [7:0] u_dat;
    bit         c_rdy;
    bit         clr;
    bit         e_ack;
    bit         e_valid;
    bit         chk_dat;
    logic [7:0] e_dat;
    int         e_cnt;
    bit         e_full;
    bit         e_ovr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit u_rdy, input logic [7:0] u_dat, input bit c_rdy, input bit clr);
    bus.uart_ready_i    = u_rdy;
    bus.uart_data_i     = u_dat;
    bus.ready_i         = c_rdy;
    bus.clear_overrun_i = clr;
  endtask

  task automatic model_clear();
    q.delete();
    m_ovr    = 1'b0;
    m_ack    = 1'b0;
    prev_rdy = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"},   int'(bus.count_o),   q.size());
    chk({tag, ".valid"},   int'(bus.valid_o),   int'(q.size() != 0));
    chk({tag, ".full"},    int'(bus.full_o),    int'(q.size() == DEPTH));
    chk({tag, ".overrun"}, int'(bus.overrun_o), int'(m_ovr));
    chk({tag, ".ack"},     int'(bus.uart_ack_o), int'(m_ack));
    if (q.size() != 0) chk({tag, ".data"}, int'(bus.data_o), int'(q[0]));
  endtask

  // One clock: the model captures on the first cycle of each Uart high period
  // (the driver always leaves >= 2 low cycles between bytes).
  task automatic step(input string tag);
    bit pop, push, acc;
    if (rand_pop) bus.ready_i = 1'($urandom_range(0, 1));
    pop  = (q.size() != 0) && bus.ready_i;
    push = bus.uart_ready_i && !prev_rdy;
    acc  = push && (q.size() < DEPTH || pop);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(bus.uart_data_i);
    if (push && !acc)             m_ovr = 1'b1;
    else if (bus.clear_overrun_i) m_ovr = 1'b0;
    m_ack    = push;
    prev_rdy = bus.uart_ready_i;
    #1;
    chk_model(tag);
  endtask

  task automatic send(input logic [7:0] d, input int hold, input int gap, input string tag);
    bus.uart_ready_i = 1'b1;
    bus.uart_data_i  = d;
    repeat (hold) step(tag);
    bus.uart_ready_i = 1'b0;
    bus.uart_data_i  = 8'($urandom_range(0, 255));
    repeat (gap) step(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst.count",   int'(bus.count_o),    0);
    chk("rst.valid",   int'(bus.valid_o),    0);
    chk("rst.full",    int'(bus.full_o),     0);
    chk("rst.overrun", int'(bus.overrun_o),  0);
    chk("rst.ack",     int'(bus.uart_ack_o), 0);
    chk("rst.data",    int'(bus.data_o),     0);
    #2 rst = 1'b0;
    model_clear();
    rand_pop = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    model_clear();
    rand_pop = 1'b0;

    // single byte held 5 cycles, pop, underflow guard, second byte, lone clear
    vecs[0] = '{1, 8'hA5, 0, 0, 1, 1, 1, 8'hA5, 1, 0, 0};
    vecs[1] = '{1, 8'hA5, 0, 0, 0, 1, 1, 8'hA5, 1, 0, 0};
    vecs[2] = '{1, 8'hA5, 0, 0, 0, 1, 1, 8'hA5, 1, 0, 0};
    vecs[3] = '{1, 8'hA5, 0, 0, 0, 1, 1, 8'hA5, 1, 0, 0};
    vecs[4] = '{1, 8'hA5, 0, 0, 0, 1, 1, 8'hA5, 1, 0, 0};
    vecs[5] = '{0, 8'h00, 0, 0, 0, 1, 1, 8'hA5, 1, 0, 0};
    vecs[6] = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0};
    vecs[7] = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0};
    vecs[8] = '{1, 8'h3C, 0, 0, 1, 1, 1, 8'h3C, 1, 0, 0};
    vecs[9] = '{0, 8'h00, 0, 1, 0, 1, 1, 8'h3C, 1, 0, 0};

    do_reset();
    foreach (vecs[i]) begin
      set_in(vecs[i].u_rdy, vecs[i].u_dat, vecs[i].c_rdy, vecs[i].clr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.ack", i),     int'(bus.uart_ack_o), int'(vecs[i].e_ack));
      chk($sformatf("vec%0d.valid", i),   int'(bus.valid_o),    int'(vecs[i].e_valid));
      chk($sformatf("vec%0d.count", i),   int'(bus.count_o),    vecs[i].e_cnt);
      chk($sformatf("vec%0d.full", i),    int'(bus.full_o),     int'(vecs[i].e_full));
      chk($sformatf("vec%0d.overrun", i), int'(bus.overrun_o),  int'(vecs[i].e_ovr));
      if (vecs[i].chk_dat) chk($sformatf("vec%0d.data", i), int'(bus.data_o), int'(vecs[i].e_dat));
    end

    // fill to 16, drop the 17th, drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1, 2, "fill");
    chk("fill.full",  int'(bus.full_o),  1);
    chk("fill.count", int'(bus.count_o), 16);
    send(8'h10, 2, 2, "drop");
    chk("drop.overrun", int'(bus.overrun_o), 1);
    chk("drop.count",   int'(bus.count_o),   16);
    bus.ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.data", int'(bus.data_o), i);
      step("drain");
    end
    bus.ready_i = 1'b0;
    chk("drain.valid", int'(bus.valid_o), 0);

    // push arriving in the same cycle as a pop on a full FIFO
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(8'(8'h80 + i), 1, 2, "fill2");
    set_in(1'b1, 8'h55, 1'b1, 1'b0);
    step("pushpop");
    bus.ready_i = 1'b0;
    bus.uart_ready_i = 1'b0;
    step("pushpop");
    step("pushpop");
    chk("pushpop.count",   int'(bus.count_o),   16);
    chk("pushpop.overrun", int'(bus.overrun_o), 0);
    bus.ready_i = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) step("drain2");
    chk("pushpop.last", int'(bus.data_o), 8'h55);
    step("drain2");
    bus.ready_i = 1'b0;

    // clear coinciding with a drop, then a lone clear
    for (int i = 0; i < DEPTH; i++) send(8'(8'hC0 + i), 1, 2, "fill3");
    set_in(1'b1, 8'hEE, 1'b0, 1'b1);
    step("clrdrop");
    bus.clear_overrun_i = 1'b0;
    bus.uart_ready_i = 1'b0;
    chk("clrdrop.overrun", int'(bus.overrun_o), 1);
    step("clrdrop");
    step("clrdrop");
    bus.clear_overrun_i = 1'b1;
    step("clr");
    bus.clear_overrun_i = 1'b0;
    chk("clr.overrun", int'(bus.overrun_o), 0);

    // 40 random bytes with a randomly stalling consumer, then drain
    do_reset();
    rand_pop = 1'b1;
    for (int i = 0; i < 40; i++)
      send(8'($urandom_range(0, 255)), $urandom_range(1, 3), $urandom_range(2, 4), "rand");
    rand_pop = 1'b0;
    bus.ready_i = 1'b1;
    repeat (20) step("rdrain");
    bus.ready_i = 1'b0;
    chk("rdrain.valid", int'(bus.valid_o), 0);

    // asynchronous reset with 7 entries and the FSM parked in WAIT_LOW
    do_reset();
    for (int i = 0; i < 6; i++) send(8'(8'h20 + i), 1, 2, "pre");
    bus.uart_ready_i = 1'b1;
    bus.uart_data_i  = 8'h26;
    repeat (3) step("pre");
    chk("pre.count", int'(bus.count_o), 7);
    #2 rst = 1'b1;
    #1;
    chk("arst.count",   int'(bus.count_o),    0);
    chk("arst.valid",   int'(bus.valid_o),    0);
    chk("arst.data",    int'(bus.data_o),     0);
    chk("arst.overrun", int'(bus.overrun_o),  0);
    chk("arst.ack",     int'(bus.uart_ack_o), 0);
    bus.uart_ready_i = 1'b0;
    #2 rst = 1'b0;
    model_clear();
    send(8'hC3, 2, 2, "post");
    chk("post.count", int'(bus.count_o), 1);
    chk("post.data",  int'(bus.data_o),  8'hC3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
